soul_ctrl: RTL



---
 rtl/soul_pkg.sv | 53 +++++
 rtl/btn_sync.sv | 33 +++
 rtl/soul_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/soul_pkg.sv
// Shared types and constants for the player-soul controller.
package soul_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned C_W     = 2 * COORD_W;
  localparam int unsigned C_X_LSB = 0;
  localparam int unsigned C_Y_LSB = COORD_W;

  localparam int unsigned BTN_W       = 5;
  localparam int unsigned BTN_UP      = 0;
  localparam int unsigned BTN_DOWN    = 1;
  localparam int unsigned BTN_LEFT    = 2;
  localparam int unsigned BTN_RIGHT   = 3;
  localparam int unsigned BTN_RESTART = 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  localparam logic [1:0] COL_SOUL  = 2'b10;
  localparam logic [1:0] COL_FLASH = 2'b00;
  localparam logic [1:0] COL_DEAD  = 2'b11;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pos_t;

  // One axis step: inc-only adds, dec-only subtracts, both/neither holds; clamp in 11 bits.
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] cur,
    input logic               inc,
    input logic               dec,
    input logic [ARITH_W-1:0] lo,
    input logic [ARITH_W-1:0] hi,
    input logic [ARITH_W-1:0] step
  );
    logic [ARITH_W-1:0] ext;
    logic [ARITH_W-1:0] sum;
    ext       = ARITH_W'(cur);
    sum       = ext + step;
    step_axis = cur;
    if (inc && !dec) begin
      step_axis = (sum > hi) ? COORD_W'(hi) : COORD_W'(sum);
    end else if (dec && !inc) begin
      step_axis = (ext < lo + step) ? COORD_W'(lo) : COORD_W'(ext - step);
    end
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous button inputs.
module btn_sync
  import soul_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/soul_ctrl.sv
// Player-soul controller: per-frame clamped movement plus hit/invulnerability/death FSM.
module soul_ctrl
  import soul_pkg::*;
#(
  parameter int unsigned X_INIT     = 320,
  parameter int unsigned Y_INIT     = 240,
  parameter int unsigned X_MIN      = 100,
  parameter int unsigned X_MAX      = 539,
  parameter int unsigned Y_MIN      = 100,
  parameter int unsigned Y_MAX      = 379,
  parameter int unsigned STEP       = 2,
  parameter int unsigned HP_MAX     = 3,
  parameter int unsigned INV_FRAMES = 60
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_restart,
  input  logic           vsync,
  input  logic           hit,
  output logic [C_W-1:0] C,
  output logic [1:0]     color,
  output logic [2:0]     hp,
  output logic           dead,
  output logic           frame_tick
);

  logic [BTN_W-1:0] btn_raw, btn_s;
  logic             vsync_prev_d, vsync_prev_q;
  logic             restart_prev_d, restart_prev_q;
  logic             restart_edge;
  state_e           state_d, state_q;
  pos_t             pos_d, pos_q;
  logic [2:0]       hp_d, hp_q;
  logic [7:0]       inv_d, inv_q;
  logic [1:0]       color_d, color_q;
  logic             dead_d, dead_q;

  assign btn_raw = {btn_restart, btn_right, btn_left, btn_down, btn_up};

  btn_sync #(.W(BTN_W)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s)
  );

  assign frame_tick   = vsync & ~vsync_prev_q;
  assign restart_edge = btn_s[BTN_RESTART] & ~restart_prev_q;

  always_comb begin
    vsync_prev_d   = vsync;
    restart_prev_d = btn_s[BTN_RESTART];
    state_d        = state_q;
    pos_d          = pos_q;
    hp_d           = hp_q;
    inv_d          = inv_q;

    if (frame_tick && (state_q != ST_DEAD)) begin
      pos_d.x = step_axis(pos_q.x, btn_s[BTN_RIGHT], btn_s[BTN_LEFT],
                          ARITH_W'(X_MIN), ARITH_W'(X_MAX), ARITH_W'(STEP));
      pos_d.y = step_axis(pos_q.y, btn_s[BTN_DOWN], btn_s[BTN_UP],
                          ARITH_W'(Y_MIN), ARITH_W'(Y_MAX), ARITH_W'(STEP));
    end

    unique case (state_q)
      ST_NORMAL: begin
        if (hit) begin
          if (hp_q <= 3'd1) begin
            state_d = ST_DEAD;
            hp_d    = 3'd0;
          end else begin
            state_d = ST_INVULN;
            hp_d    = hp_q - 3'd1;
            inv_d   = 8'(INV_FRAMES);
          end
        end
      end
      ST_INVULN: begin
        if (frame_tick) begin
          if (inv_q <= 8'd1) begin
            state_d = ST_NORMAL;
            inv_d   = 8'd0;
          end else begin
            inv_d = inv_q - 8'd1;
          end
        end
      end
      ST_DEAD: begin
        // Restart overrides any concurrent hit.
        if (restart_edge) begin
          state_d = ST_NORMAL;
          hp_d    = 3'(HP_MAX);
          pos_d.x = COORD_W'(X_INIT);
          pos_d.y = COORD_W'(Y_INIT);
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    unique case (state_d)
      ST_INVULN: color_d = inv_d[2] ? COL_FLASH : COL_SOUL;
      ST_DEAD:   color_d = COL_DEAD;
      default:   color_d = COL_SOUL;
    endcase
    dead_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_q   <= 1'b0;
      restart_prev_q <= 1'b0;
      state_q        <= ST_NORMAL;
      pos_q.x        <= COORD_W'(X_INIT);
      pos_q.y        <= COORD_W'(Y_INIT);
      hp_q           <= 3'(HP_MAX);
      inv_q          <= 8'd0;
      color_q        <= COL_SOUL;
      dead_q         <= 1'b0;
    end else begin
      vsync_prev_q   <= vsync_prev_d;
      restart_prev_q <= restart_prev_d;
      state_q        <= state_d;
      pos_q          <= pos_d;
      hp_q           <= hp_d;
      inv_q          <= inv_d;
      color_q        <= color_d;
      dead_q         <= dead_d;
    end
  end

  assign C[C_X_LSB +: COORD_W] = pos_q.x;
  assign C[C_Y_LSB +: COORD_W] = pos_q.y;
  assign color = color_q;
  assign hp    = hp_q;
  assign dead  = dead_q;

endmodule
